ota_trim_sar: RTL
=================

OTA_TRIM_SAR -- requirements
Module: ota_trim_sar

Interface
REQ-001 SHALL have parameter TRIM_W, default 6, width of the offset-trim code driven into the OTA switch bank.
REQ-002 SHALL have parameter SETTLE, default 4, number of analog settle cycles per trial bit; legal range 2..255.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-006 SHALL have port start  input  1  request to begin auto-calibration.
REQ-007 SHALL have port manual_en  input  1  selects the directly loaded trim code.
REQ-008 SHALL have port manual_code  input  TRIM_W  code to load when manual_en is high.
REQ-009 SHALL have port cmp_in  input  1  OTA-as-comparator output, asynchronous to clk.
REQ-010 SHALL have port trim_code  output  TRIM_W  registered trim code to the OTA trim switches.
REQ-011 SHALL have port busy  output  1  high while calibration runs.
REQ-012 SHALL have port done  output  1  high after calibration completes, until cleared.

Function
REQ-013 SHALL pass cmp_in through a 2-flop synchronizer (reset 0) into cmp_sync; only cmp_sync is used.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; a down-counter cnt (8 bit) and bit index idx (clog2 TRIM_W bits).
REQ-015 SHALL, in IDLE or DONE with ena=1 and start=1, at that edge (E0): trim_code <= MSB-only (1<<(TRIM_W-1)), idx <= TRIM_W-1, cnt <= SETTLE, busy <= 1, done <= 0, state <= RUN.
REQ-016 SHALL, in RUN with cnt != 0, decrement cnt each enabled cycle, trim_code unchanged.
REQ-017 SHALL, in RUN with cnt == 0: bit idx of trim_code <= cmp_sync (1 keeps, 0 clears); if idx != 0, also set bit idx-1, idx <= idx-1, cnt <= SETTLE; if idx == 0, state <= DONE, busy <= 0, done <= 1.
REQ-018 SHALL apply each trial bit exactly SETTLE+1 cycles before its decision; done rises at edge E0 + TRIM_W*(SETTLE+1).
REQ-019 SHALL, in IDLE or DONE with manual_en=1 and start=0, load trim_code <= manual_code at the next edge and clear done; start has priority when both are high.
REQ-020 SHALL ignore start and manual_en while busy=1; calibration runs to completion.
REQ-021 SHALL hold state, cnt, idx, trim_code, busy, done unchanged while ena=0; synchronizer keeps running.
REQ-022 SHALL hold trim_code in DONE until a new start or manual load; done is a level, not a pulse.
REQ-023 SHALL never drive trim_code from combinational logic; all outputs registered.

Reset
REQ-024 SHALL, on rst_n low at any time (including mid-RUN), asynchronously force state=IDLE, trim_code=0, busy=0, done=0, cnt=0, idx=0, synchronizer=0.
REQ-025 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; no start is implied by reset release.

Verification (TRIM_W=6, SETTLE=4, ena=1 unless stated)
REQ-026 SHALL verify: cmp_in held 1, start pulse at E0 -> busy 1 at E0, trim_code=63, done=1 and busy=0 at E0+30.
REQ-027 SHALL verify: cmp_in held 0, start -> trim_code=0 at E0+30, done=1; intermediate trials 32,16,8,4,2,1 each visible for 5 cycles.
REQ-028 SHALL verify: comparator model cmp_in = (trim_code <= 37) -> final trim_code=37 (100101b), done at E0+30.
REQ-029 SHALL verify: rst_n low at E0+12 -> trim_code=0, busy=0 immediately (no clock); start after release restarts from 32.
REQ-030 SHALL verify: manual_en=1, manual_code=21 in IDLE -> trim_code=21 next edge; same request and a second start while busy -> ignored, run result unchanged.
REQ-031 SHALL verify: ena=0 for 7 cycles mid-RUN -> trim_code and cnt frozen, done delayed to E0+37, result identical to undisturbed run.

Source files
------------

// File: rtl/ota_trim_sar.sv
// ota_trim_sar: successive-approximation offset-trim calibrator for an OTA,
// with manual code load, global enable freeze and a 2-flop comparator synchronizer.
module ota_trim_sar #(
    parameter int TRIM_W = 6,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              manual_en,
    input  logic [TRIM_W-1:0] manual_code,
    input  logic              cmp_in,
    output logic [TRIM_W-1:0] trim_code,
    output logic              busy,
    output logic              done
);
    localparam int IW = TRIM_W > 1 ? $clog2(TRIM_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic [IW-1:0]     idx;
    logic              cmp_meta;
    logic              cmp_sync;
    logic [TRIM_W-1:0] bit_m;
    logic [TRIM_W-1:0] decided;

    // The synchronizer keeps sampling even while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_sync <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_sync <= cmp_meta;
        end
    end

    // Trial bit under test is kept when the comparator says 1, cleared otherwise.
    always_comb begin
        bit_m   = TRIM_W'(1) << idx;
        decided = cmp_sync ? trim_code : (trim_code & ~bit_m);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            trim_code <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
        end else if (ena) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        trim_code <= TRIM_W'(1) << (TRIM_W - 1);
                        idx       <= IW'(TRIM_W - 1);
                        cnt       <= 8'(SETTLE);
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= RUN;
                    end else if (manual_en) begin
                        trim_code <= manual_code;
                        done      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (idx != '0) begin
                        trim_code <= decided | (bit_m >> 1);
                        idx       <= idx - 1'b1;
                        cnt       <= 8'(SETTLE);
                    end else begin
                        trim_code <= decided;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
